system_config_loader: RTL and testbench
=======================================

// Module: system_config_loader
// PURPOSE
//  Writer side of types::system_config. Parses a per-game config record streamed from the dataslot/bridge
//  (8-bit valid/ready), checks header and checksum, and atomically commits a fully populated
//  system_config to the core (MPU select, screen geometry, input matrix). Sits between bridge download
//  logic and the core top; the config consumer only ever sees a complete, validated record.
// PARAMETERS
//  MAGIC            16'h4757  expected header bytes, received high byte first ("G","W")
//  VERSION          8'h01     required record version byte
//  TIMEOUT_CYCLES   1000000   max clk cycles between accepted bytes while loading; 0 disables timeout
// PORTS
//  clk             in   1    core clock
//  reset_n         in   1    asynchronous, active-low reset
//  start           in   1    1-cycle pulse: begin a new record (aborts any load in progress)
//  byte_valid      in   1    byte_data is valid
//  byte_data       in   8    record byte
//  byte_ready      out  1    loader accepts byte_data this cycle (transfer = valid & ready)
//  busy            out  1    load in progress
//  done            out  1    1-cycle pulse on successful commit
//  error           out  1    sticky: last load failed; cleared by start
//  err_code        out  3    0 none, 1 magic, 2 version, 3 checksum, 4 timeout
//  config_valid    out  1    sticky: config_out holds a committed record
//  config_out      out  struct types::system_config, committed record
// BEHAVIOUR
//  Reset: every output 0, config_out all fields 0, state IDLE, shadow and checksum cleared.
//  Record layout (45 bytes): MAGIC[15:8], MAGIC[7:0], VERSION, 41-byte payload, checksum.
//  Payload offsets (multi-byte little-endian): 0 mpu; 1 screen_config; 2-3 screen_width; 4-5 screen_height;
//   6-37 input_s0..s7_config, 4 bytes each; 38 input_b_config; 39 input_ba_config; 40 input_acl_config.
//   For width/height, bits [15:12] of the 16-bit value are discarded.
//  States: IDLE -> MAGIC0 -> MAGIC1 -> VER -> PAYLOAD (6-bit idx 0..40) -> CSUM -> COMMIT -> IDLE;
//   any check failure -> FAIL -> IDLE.
//  byte_ready = 1 only in MAGIC0/MAGIC1/VER/PAYLOAD/CSUM; busy = 1 in those states and COMMIT.
//  Each accepted byte is checked in the cycle it transfers. Mismatch in MAGIC0/MAGIC1 -> err 1.
//   Mismatch in VER -> err 2. FAIL lasts 1 cycle; it sets error and err_code, and byte_ready is 0.
//  Payload bytes are written into a shadow system_config only. config_out is untouched until COMMIT.
//  sum: 8-bit wrapping sum of all 45 bytes, including the checksum byte. It must equal 8'h00.
//  COMMIT (1 cycle after checksum transfer): config_out <= shadow, config_valid <= 1, done = 1 for 1 cycle.
//  start in any state: next state MAGIC0, error/err_code/idx/sum cleared. config_out and config_valid are kept.
//   If start and byte_valid are both high in the same cycle, start wins and that byte is not accepted.
//  Timeout: counter reloads on every transfer and on start, and counts while in a byte_ready state.
//   On reaching TIMEOUT_CYCLES -> FAIL, err 4.
//  byte_valid while IDLE: ignored (byte_ready = 0). Bytes after CSUM: not accepted until the next start.
//  Failed load: previous committed config_out and config_valid are unchanged.
//  reset_n low mid-load: immediate return to reset values, including config_out and config_valid.
// CONFIGURATION
//  CONFIG_CHECKSUM_EN defined: sum != 0 at CSUM -> FAIL, err 3, no commit.
//  CONFIG_CHECKSUM_EN undefined: checksum byte is still consumed (45-byte record), its value is ignored,
//   and the load always commits. The sum logic is removed.
// TESTING
//  1. start; valid record with mpu=8'h02, width=16'h0140, height=16'h00F0, s0=32'h00010203, correct checksum
//     -> done pulses exactly once, 1 cycle after checksum; config_valid=1; screen_width=12'd320;
//     screen_height=12'd240; input_s0_config=32'h00010203.
//  2. After test 1, start then first byte 8'h00 -> 1 cycle later error=1, err_code=1, byte_ready=0,
//     config_out still equals the test-1 values.
//  3. Record with checksum+1 -> with CONFIG_CHECKSUM_EN: err_code=3, no done, config_out unchanged;
//     without it: done pulses and the record commits.
//  4. start, 3 header bytes, then byte_valid=0 for TIMEOUT_CYCLES (test param 100) -> error=1, err_code=4, busy=0.
//  5. reset_n low after 10 payload bytes -> all outputs 0 asynchronously; release, start, full record -> commits.
//  6. start pulsed together with byte_valid at payload idx 20 -> that byte is dropped; a new 45-byte record commits;
//     valid VERSION=8'h02 header -> err_code=2.

Source files
------------

// File: rtl/system_config_loader.sv
// Streams, validates and atomically commits a per-game system_config record.
// Optional: define CONFIG_CHECKSUM_EN to reject records whose byte sum is non-zero.
package types;
  typedef struct packed {
    logic [7:0]  mpu;
    logic [7:0]  screen_config;
    logic [11:0] screen_width;
    logic [11:0] screen_height;
    logic [31:0] input_s0_config;
    logic [31:0] input_s1_config;
    logic [31:0] input_s2_config;
    logic [31:0] input_s3_config;
    logic [31:0] input_s4_config;
    logic [31:0] input_s5_config;
    logic [31:0] input_s6_config;
    logic [31:0] input_s7_config;
    logic [7:0]  input_b_config;
    logic [7:0]  input_ba_config;
    logic [7:0]  input_acl_config;
  } system_config;
endpackage

module system_config_loader
  import types::*;
#(
  parameter logic [15:0] MAGIC = 16'h4757,
  parameter logic [7:0] VERSION = 8'h01,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         byte_valid,
  input  logic [7:0]   byte_data,
  output logic         byte_ready,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [2:0]   err_code,
  output logic         config_valid,
  output system_config config_out
);

  typedef enum logic [2:0] {
    IDLE, MAGIC0, MAGIC1, VER, PAYLOAD, CSUM, COMMIT, FAIL
  } state_t;

  state_t       state;
  logic [5:0]   idx;
  logic [31:0]  tcnt;
  system_config sh;
  logic         xfer;
  logic         tmo;
  logic [4:0]   off;

  assign byte_ready = (state == MAGIC0) | (state == MAGIC1) |
                      (state == VER) | (state == PAYLOAD) |
                      (state == CSUM);
  assign busy = byte_ready | (state == COMMIT);
  // start wins over a byte presented in the same cycle
  assign xfer = byte_valid & byte_ready & ~start;
  assign tmo  = (TIMEOUT_CYCLES != 0) && byte_ready && !xfer &&
                (tcnt == TIMEOUT_CYCLES - 32'd1);
  assign off  = 5'(idx - 6'd6);

`ifdef CONFIG_CHECKSUM_EN
  logic [7:0] sum;
  logic [7:0] sum_next;
  assign sum_next = sum + byte_data;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      idx          <= '0;
      tcnt         <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_code     <= 3'd0;
      config_valid <= 1'b0;
      config_out   <= '0;
`ifdef CONFIG_CHECKSUM_EN
      sum          <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (start) begin
        state    <= MAGIC0;
        idx      <= '0;
        tcnt     <= '0;
        error    <= 1'b0;
        err_code <= 3'd0;
`ifdef CONFIG_CHECKSUM_EN
        sum      <= '0;
`endif
      end else if (tmo) begin
        state    <= FAIL;
        error    <= 1'b1;
        err_code <= 3'd4;
      end else begin
        if (byte_ready) tcnt <= xfer ? '0 : tcnt + 32'd1;
`ifdef CONFIG_CHECKSUM_EN
        if (xfer) sum <= sum_next;
`endif
        unique case (state)
          MAGIC0, MAGIC1: if (xfer) begin
            if (byte_data == ((state == MAGIC0) ? MAGIC[15:8] : MAGIC[7:0]))
              state <= (state == MAGIC0) ? MAGIC1 : VER;
            else begin
              state    <= FAIL;
              error    <= 1'b1;
              err_code <= 3'd1;
            end
          end
          VER: if (xfer) begin
            idx <= '0;
            if (byte_data == VERSION) state <= PAYLOAD;
            else begin
              state    <= FAIL;
              error    <= 1'b1;
              err_code <= 3'd2;
            end
          end
          PAYLOAD: if (xfer) begin
            if (idx == 6'd40) state <= CSUM;
            else idx <= idx + 6'd1;
          end
          CSUM: if (xfer) begin
`ifdef CONFIG_CHECKSUM_EN
            if (sum_next != 8'h00) begin
              state    <= FAIL;
              error    <= 1'b1;
              err_code <= 3'd3;
            end else
`endif
            begin
              state        <= COMMIT;
              config_out   <= sh;
              config_valid <= 1'b1;
              done         <= 1'b1;
            end
          end
          COMMIT, FAIL: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Payload lands in the shadow only; config_out sees it at commit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh <= '0;
    end else if (state == PAYLOAD && xfer) begin
      case (idx)
        6'd0:  sh.mpu                <= byte_data;
        6'd1:  sh.screen_config      <= byte_data;
        6'd2:  sh.screen_width[7:0]  <= byte_data;
        6'd3:  sh.screen_width[11:8] <= byte_data[3:0];
        6'd4:  sh.screen_height[7:0] <= byte_data;
        6'd5:  sh.screen_height[11:8] <= byte_data[3:0];
        6'd38: sh.input_b_config     <= byte_data;
        6'd39: sh.input_ba_config    <= byte_data;
        6'd40: sh.input_acl_config   <= byte_data;
        default: begin
          case (off[4:2])
            3'd0: sh.input_s0_config[{off[1:0], 3'b000} +: 8] <= byte_data;
            3'd1: sh.input_s1_config[{off[1:0], 3'b000} +: 8] <= byte_data;
            3'd2: sh.input_s2_config[{off[1:0], 3'b000} +: 8] <= byte_data;
            3'd3: sh.input_s3_config[{off[1:0], 3'b000} +: 8] <= byte_data;
            3'd4: sh.input_s4_config[{off[1:0], 3'b000} +: 8] <= byte_data;
            3'd5: sh.input_s5_config[{off[1:0], 3'b000} +: 8] <= byte_data;
            3'd6: sh.input_s6_config[{off[1:0], 3'b000} +: 8] <= byte_data;
            default: sh.input_s7_config[{off[1:0], 3'b000} +: 8] <= byte_data;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_system_config_loader.sv
// Directed bench for system_config_loader.
// Honours CONFIG_CHECKSUM_EN the same way the design does.
module tb_system_config_loader;
  import types::*;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic         byte_valid;
  logic [7:0]   byte_data;
  logic         byte_ready;
  logic         busy;
  logic         done;
  logic         error;
  logic [2:0]   err_code;
  logic         config_valid;
  system_config config_out;

  int tests = 0;
  int fails = 0;

  logic [7:0]   rec [45];
  system_config exp1;
  system_config exp;

  always #5 clk = ~clk;

  system_config_loader #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .busy(busy), .done(done),
    .error(error), .err_code(err_code),
    .config_valid(config_valid), .config_out(config_out)
  );

  // Build rec[] from a config; w16/h16 carry the raw 16-bit values
  task automatic build(input system_config c, input logic [7:0] ver,
                       input logic [15:0] w16, input logic [15:0] h16);
    logic [7:0] s;
    logic [31:0] sv [8];
    sv[0] = c.input_s0_config; sv[1] = c.input_s1_config;
    sv[2] = c.input_s2_config; sv[3] = c.input_s3_config;
    sv[4] = c.input_s4_config; sv[5] = c.input_s5_config;
    sv[6] = c.input_s6_config; sv[7] = c.input_s7_config;
    rec[0] = 8'h47; rec[1] = 8'h57; rec[2] = ver;
    rec[3] = c.mpu; rec[4] = c.screen_config;
    rec[5] = w16[7:0]; rec[6] = w16[15:8];
    rec[7] = h16[7:0]; rec[8] = h16[15:8];
    for (int i = 0; i < 8; i++)
      for (int b = 0; b < 4; b++)
        rec[9 + 4*i + b] = sv[i][8*b +: 8];
    rec[41] = c.input_b_config;
    rec[42] = c.input_ba_config;
    rec[43] = c.input_acl_config;
    s = 8'h00;
    for (int i = 0; i < 44; i++) s = s + rec[i];
    rec[44] = 8'h00 - s;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w;
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    w = 0;
    while (!byte_ready && w < 8) begin
      @(negedge clk);
      w++;
    end
    if (!byte_ready) begin
      tests++; fails++;
      $display("FAIL send_wait: byte_ready=%b required 1", byte_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_rec(input int n);
    for (int i = 0; i < n; i++) send_byte(rec[i]);
    byte_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    #3;
    tests++;
    if ({byte_ready, busy, done, error, err_code, config_valid} !== 8'h00) begin
      fails++;
      $display("FAIL reset_outs: got %b required 00000000",
               {byte_ready, busy, done, error, err_code, config_valid});
    end
    tests++;
    if (config_out !== '0) begin
      fails++; $display("FAIL reset_cfg: got %h required 0", config_out);
    end
    @(negedge clk); reset_n = 1'b1;
    byte_valid = 1'b1; byte_data = 8'h47;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (byte_ready !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_ignore: ready=%b busy=%b required 0 0", byte_ready, busy);
    end
    byte_valid = 1'b0;
  endtask

  task automatic test_valid_record();
    exp1 = '0;
    exp1.mpu = 8'h02; exp1.screen_config = 8'h5A;
    exp1.screen_width = 12'd320; exp1.screen_height = 12'd240;
    exp1.input_s0_config = 32'h00010203;
    exp1.input_s3_config = 32'h89ABCDEF;
    exp1.input_s7_config = 32'hDEADBEEF;
    exp1.input_b_config = 8'h11; exp1.input_ba_config = 8'h22;
    exp1.input_acl_config = 8'h33;
    build(exp1, 8'h01, 16'h0140, 16'h00F0);
    pulse_start();
    tests++;
    if (busy !== 1'b1 || byte_ready !== 1'b1) begin
      fails++; $display("FAIL start_busy: busy=%b ready=%b required 1 1", busy, byte_ready);
    end
    send_rec(44);
    tests++;
    if (done !== 1'b0 || config_valid !== 1'b0) begin
      fails++; $display("FAIL early_commit: done=%b valid=%b required 0 0", done, config_valid);
    end
    send_byte(rec[44]);
    byte_valid = 1'b0;
    tests++;
    if (done !== 1'b1 || config_valid !== 1'b1) begin
      fails++; $display("FAIL commit: done=%b valid=%b required 1 1", done, config_valid);
    end
    tests++;
    if (config_out !== exp1) begin
      fails++; $display("FAIL cfg1: got %h required %h", config_out, exp1);
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || byte_ready !== 1'b0) begin
      fails++;
      $display("FAIL after_commit: done=%b busy=%b ready=%b required 0 0 0",
               done, busy, byte_ready);
    end
  endtask

  task automatic test_bad_magic();
    pulse_start();
    send_byte(8'h00);
    byte_valid = 1'b0;
    tests++;
    if (error !== 1'b1 || err_code !== 3'd1 || byte_ready !== 1'b0) begin
      fails++;
      $display("FAIL magic_err: error=%b code=%0d ready=%b required 1 1 0",
               error, err_code, byte_ready);
    end
    tests++;
    if (config_out !== exp1 || config_valid !== 1'b1) begin
      fails++; $display("FAIL magic_keep: got %h v=%b required %h v=1",
                        config_out, config_valid, exp1);
    end
  endtask

  task automatic test_checksum();
    exp = exp1;
    exp.mpu = 8'h07;
    build(exp, 8'h01, 16'h0140, 16'h00F0);
    rec[44] = rec[44] + 8'h01;
    pulse_start();
    tests++;
    if (error !== 1'b0 || err_code !== 3'd0) begin
      fails++; $display("FAIL start_clear: error=%b code=%0d required 0 0", error, err_code);
    end
    send_rec(45);
`ifdef CONFIG_CHECKSUM_EN
    tests++;
    if (error !== 1'b1 || err_code !== 3'd3 || done !== 1'b0) begin
      fails++; $display("FAIL csum_err: error=%b code=%0d done=%b required 1 3 0",
                        error, err_code, done);
    end
    tests++;
    if (config_out !== exp1) begin
      fails++; $display("FAIL csum_keep: got %h required %h", config_out, exp1);
    end
`else
    tests++;
    if (done !== 1'b1 || error !== 1'b0) begin
      fails++; $display("FAIL csum_ignored: done=%b error=%b required 1 0", done, error);
    end
    tests++;
    if (config_out !== exp) begin
      fails++; $display("FAIL csum_cfg: got %h required %h", config_out, exp);
    end
`endif
  endtask

  task automatic test_timeout();
    build(exp1, 8'h01, 16'h0140, 16'h00F0);
    pulse_start();
    send_rec(3);
    repeat (99) @(posedge clk);
    #1;
    tests++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL tmo_early: error=%b busy=%b required 0 1", error, busy);
    end
    @(posedge clk); #1;
    tests++;
    if (error !== 1'b1 || err_code !== 3'd4 || busy !== 1'b0) begin
      fails++; $display("FAIL tmo: error=%b code=%0d busy=%b required 1 4 0",
                        error, err_code, busy);
    end
  endtask

  task automatic test_reset_mid_load();
    exp = '0;
    exp.mpu = 8'h03; exp.screen_config = 8'hC3;
    exp.screen_width = 12'h140; exp.screen_height = 12'h0F0;
    exp.input_s1_config = 32'h13579BDF;
    exp.input_s6_config = 32'h2468ACE0;
    exp.input_acl_config = 8'h44;
    build(exp, 8'h01, 16'hF140, 16'hA0F0);
    pulse_start();
    send_rec(13);
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if ({byte_ready, busy, done, error, err_code, config_valid} !== 8'h00 ||
        config_out !== '0) begin
      fails++;
      $display("FAIL async_reset: outs=%b cfg=%h required all 0",
               {byte_ready, busy, done, error, err_code, config_valid}, config_out);
    end
    @(negedge clk); reset_n = 1'b1;
    pulse_start();
    send_rec(45);
    tests++;
    if (done !== 1'b1 || config_out !== exp) begin
      fails++; $display("FAIL reset_reload: done=%b got %h required %h",
                        done, config_out, exp);
    end
  endtask

  task automatic test_start_abort();
    exp = exp1;
    exp.mpu = 8'h09; exp.input_s4_config = 32'hCAFEF00D;
    exp.input_ba_config = 8'h5C;
    build(exp1, 8'h01, 16'h0140, 16'h00F0);
    pulse_start();
    send_rec(23);
    @(negedge clk);
    start = 1'b1; byte_valid = 1'b1; byte_data = 8'h47;
    @(posedge clk);
    #1 start = 1'b0; byte_valid = 1'b0;
    tests++;
    if (byte_ready !== 1'b1 || error !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL abort_state: ready=%b error=%b done=%b required 1 0 0",
                        byte_ready, error, done);
    end
    build(exp, 8'h01, 16'h0140, 16'h00F0);
    send_rec(45);
    tests++;
    if (done !== 1'b1 || config_out !== exp) begin
      fails++; $display("FAIL abort_reload: done=%b got %h required %h",
                        done, config_out, exp);
    end
  endtask

  task automatic test_bad_version();
    build(exp1, 8'h02, 16'h0140, 16'h00F0);
    pulse_start();
    send_rec(3);
    tests++;
    if (error !== 1'b1 || err_code !== 3'd2) begin
      fails++; $display("FAIL version: error=%b code=%0d required 1 2", error, err_code);
    end
    tests++;
    if (config_out !== exp || config_valid !== 1'b1) begin
      fails++; $display("FAIL version_keep: got %h required %h", config_out, exp);
    end
  endtask

  initial begin
    test_reset();
    test_valid_record();
    test_bad_magic();
    test_checksum();
    test_timeout();
    test_reset_mid_load();
    test_start_abort();
    test_bad_version();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
